// File: rtl/axi_mm_pkg.sv
// Shared encodings for the AXI slave word memory: burst types, response codes and FSM states.
package axi_mm_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

endpackage

// File: rtl/axi_mm_bytewr_ram.sv
// Simple dual-port word RAM: one byte-enabled write port, one read port with a registered output.
module axi_mm_bytewr_ram #(
  parameter int DWIDTH    = 64,
  parameter int MEM_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [DWIDTH/8-1:0]          wstrb,
  input  logic [$clog2(MEM_WORDS)-1:0] waddr,
  input  logic [DWIDTH-1:0]            wdata,
  input  logic                         re,
  input  logic [$clog2(MEM_WORDS)-1:0] raddr,
  output logic [DWIDTH-1:0]            rdata
);

  localparam int unsigned NBYTES = DWIDTH / 8;

  logic [DWIDTH-1:0] mem_q [MEM_WORDS];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (wstrb[b]) mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Output register holds while re is low; a same-cycle write returns the old word.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_mm_user_slave_mem.sv
// AXI4 slave word memory serving INCR/FIXED bursts; independent write and read FSMs around a byte-write RAM.
module axi_mm_user_slave_mem
  import axi_mm_pkg::*;
#(
  parameter int ADDRWIDTH = 32,
  parameter int DWIDTH    = 64,
  parameter int IDWIDTH   = 4,
  parameter int MEM_WORDS = 256
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr_n,
  input  logic [IDWIDTH-1:0]   awid,
  input  logic [ADDRWIDTH-1:0] awaddr,
  input  logic [7:0]           awlen,
  input  logic [2:0]           awsize,
  input  logic [1:0]           awburst,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [DWIDTH-1:0]    wdata,
  input  logic [DWIDTH/8-1:0]  wstrb,
  input  logic                 wlast,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [IDWIDTH-1:0]   bid,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [IDWIDTH-1:0]   arid,
  input  logic [ADDRWIDTH-1:0] araddr,
  input  logic [7:0]           arlen,
  input  logic [2:0]           arsize,
  input  logic [1:0]           arburst,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [IDWIDTH-1:0]   rid,
  output logic [DWIDTH-1:0]    rdata,
  output logic [1:0]           rresp,
  output logic                 rlast,
  output logic                 rvalid,
  input  logic                 rready
);

  localparam int MW  = $clog2(MEM_WORDS);
  localparam int WIW = ADDRWIDTH - 3;
  localparam logic [WIW:0] LIMIT = (WIW+1)'(MEM_WORDS);

  // Whole-burst check at address time; DECERR comes from the last beat's word index.
  function automatic resp_e burst_status(input logic [WIW-1:0] widx, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
    logic [WIW:0] last_idx;
    last_idx = {1'b0, widx};
    if (burst == BURST_INCR) last_idx = last_idx + (WIW+1)'(len);
    if (size != 3'd3 || burst == BURST_WRAP || burst == BURST_RSVD) return RESP_SLVERR;
    if (last_idx >= LIMIT) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  wstate_e            w_state_q, w_state_d;
  logic               awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [IDWIDTH-1:0] bid_q, bid_d;
  resp_e              bresp_q, bresp_d, wstatus_q, wstatus_d;
  logic [7:0]         wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [1:0]         wburst_q, wburst_d;
  logic [MW-1:0]      widx_q, widx_d;
  logic               wlast_err_q, wlast_err_d;
  logic               ram_we;

  rstate_e            r_state_q, r_state_d;
  logic               arready_q, arready_d, rvalid_q, rvalid_d;
  logic [IDWIDTH-1:0] rid_q, rid_d;
  resp_e              rstatus_q, rstatus_d;
  logic [7:0]         rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [1:0]         rburst_q, rburst_d;
  logic [MW-1:0]      ridx_q, ridx_d, ridx_nxt, ram_ridx;
  logic               ram_re;
  logic [DWIDTH-1:0]  ram_rdata;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{awaddr[2:0], araddr[2:0]};

  always_comb begin
    w_state_d   = w_state_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    wstatus_d   = wstatus_q;
    wlen_d      = wlen_q;
    wbeat_d     = wbeat_q;
    wburst_d    = wburst_q;
    widx_d      = widx_q;
    wlast_err_d = wlast_err_q;
    ram_we      = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready_q) begin
          awready_d   = 1'b0;
          wready_d    = 1'b1;
          bid_d       = awid;
          widx_d      = awaddr[MW+2:3];
          wlen_d      = awlen;
          wburst_d    = awburst;
          wbeat_d     = '0;
          wlast_err_d = 1'b0;
          wstatus_d   = burst_status(awaddr[ADDRWIDTH-1:3], awlen, awsize, awburst);
          w_state_d   = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          ram_we  = (wstatus_q == RESP_OKAY);
          wbeat_d = wbeat_q + 8'd1;
          if (wburst_q == BURST_INCR) widx_d = widx_q + MW'(1);
          if (wbeat_q == wlen_q) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            w_state_d = W_RESP;
            if (wstatus_q != RESP_OKAY)        bresp_d = wstatus_q;
            else if (wlast_err_q || !wlast)    bresp_d = RESP_SLVERR;
            else                               bresp_d = RESP_OKAY;
          end else if (wlast) begin
            wlast_err_d = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // The next word is fetched on the accepting handshake so beats stream back-to-back.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rstatus_d = rstatus_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    rburst_d  = rburst_q;
    ridx_d    = ridx_q;
    ridx_nxt  = (rburst_q == BURST_INCR) ? ridx_q + MW'(1) : ridx_q;
    ram_re    = 1'b0;
    ram_ridx  = ridx_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = arid;
          rlen_d    = arlen;
          rburst_d  = arburst;
          rbeat_d   = '0;
          rstatus_d = burst_status(araddr[ADDRWIDTH-1:3], arlen, arsize, arburst);
          ridx_d    = araddr[MW+2:3];
          ram_re    = 1'b1;
          ram_ridx  = araddr[MW+2:3];
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && rready) begin
          if (rbeat_q == rlen_q) begin
            rvalid_d  = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            rbeat_d  = rbeat_q + 8'd1;
            ridx_d   = ridx_nxt;
            ram_re   = 1'b1;
            ram_ridx = ridx_nxt;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      w_state_q   <= W_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= RESP_OKAY;
      wstatus_q   <= RESP_OKAY;
      wlen_q      <= '0;
      wbeat_q     <= '0;
      wburst_q    <= '0;
      widx_q      <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      wstatus_q   <= wstatus_d;
      wlen_q      <= wlen_d;
      wbeat_q     <= wbeat_d;
      wburst_q    <= wburst_d;
      widx_q      <= widx_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rstatus_q <= RESP_OKAY;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rburst_q  <= '0;
      ridx_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rstatus_q <= rstatus_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      rburst_q  <= rburst_d;
      ridx_q    <= ridx_d;
    end
  end

  axi_mm_bytewr_ram #(
    .DWIDTH   (DWIDTH),
    .MEM_WORDS(MEM_WORDS)
  ) u_ram (
    .clk  (clk_wr),
    .we   (ram_we),
    .wstrb(wstrb),
    .waddr(widx_q),
    .wdata(wdata),
    .re   (ram_re),
    .raddr(ram_ridx),
    .rdata(ram_rdata)
  );

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = (rvalid_q && rstatus_q == RESP_OKAY) ? ram_rdata : '0;
  assign rresp   = rvalid_q ? rstatus_q : RESP_OKAY;
  assign rlast   = rvalid_q && (rbeat_q == rlen_q);

endmodule
